// File: rtl/seq_counter.sv
// seq_counter: step-pattern generator with ring, Johnson, binary and Gray modes, selectable at runtime.
// Optional build macro SEQCNT_RECOVER_EN: an advance from an illegal state reloads the mode seed.
module seq_counter #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             load,
   input  logic             dir,
   input  logic [1:0]       mode,
   input  logic [WIDTH-1:0] data_in,
   output logic [WIDTH-1:0] count,
   output logic             wrap,
   output logic             illegal
);

   typedef enum logic [1:0] {
      MODE_RING    = 2'd0,
      MODE_JOHNSON = 2'd1,
      MODE_BINARY  = 2'd2,
      MODE_GRAY    = 2'd3
   } mode_e;

   localparam logic [WIDTH-1:0] ZERO     = '0;
   localparam logic [WIDTH-1:0] ALL_ONES = '1;
   localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic [WIDTH-1:0] MSB_ONLY = {1'b1, {(WIDTH-1){1'b0}}};

   function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
      logic [WIDTH-1:0] b;
      b = g;
      for (int i = WIDTH - 2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

   function automatic logic [WIDTH-1:0] bin2gray(input logic [WIDTH-1:0] b);
      return b ^ (b >> 1);
   endfunction

   mode_e            mode_sel;
   logic [WIDTH-1:0] count_q, count_d;
   logic             wrap_q, wrap_d;

   logic [WIDTH-1:0] ring_fwd, ring_rev;
   logic [WIDTH-1:0] john_fwd, john_rev;
   logic [WIDTH-1:0] bin_fwd, bin_rev;
   logic [WIDTH-1:0] gray_bin, gray_fwd, gray_rev;
   logic             ring_legal, john_legal;
   logic [WIDTH-1:0] step_val;
   logic             step_wrap;

   assign mode_sel = mode_e'(mode);

   assign ring_fwd = {count_q[WIDTH-2:0], count_q[WIDTH-1]};
   assign ring_rev = {count_q[0], count_q[WIDTH-1:1]};
   assign john_fwd = {count_q[WIDTH-2:0], ~count_q[WIDTH-1]};
   assign john_rev = {~count_q[0], count_q[WIDTH-1:1]};
   assign bin_fwd  = count_q + ONE;
   assign bin_rev  = count_q - ONE;
   assign gray_bin = gray2bin(count_q);
   assign gray_fwd = bin2gray(gray_bin + ONE);
   assign gray_rev = bin2gray(gray_bin - ONE);

   // Johnson codes are exactly the words with at most one neighbouring-bit change.
   assign ring_legal = ($countones(count_q) == 1);
   assign john_legal = ($countones(count_q[WIDTH-1:1] ^ count_q[WIDTH-2:0]) <= 1);

   always_comb begin
      illegal = 1'b0;
      case (mode_sel)
         MODE_RING:    illegal = ~ring_legal;
         MODE_JOHNSON: illegal = ~john_legal;
         MODE_BINARY:  illegal = 1'b0;
         MODE_GRAY:    illegal = 1'b0;
         default:      illegal = 1'b0;
      endcase
   end

   // Candidate step and whether it leaves the sequence's terminal state.
   always_comb begin
      step_val  = count_q;
      step_wrap = 1'b0;
      case (mode_sel)
         MODE_RING: begin
            step_val  = dir ? ring_rev : ring_fwd;
            step_wrap = dir ? (count_q == ONE) : (count_q == MSB_ONLY);
         end
         MODE_JOHNSON: begin
            step_val  = dir ? john_rev : john_fwd;
            step_wrap = dir ? (count_q == ZERO) : (count_q == MSB_ONLY);
         end
         MODE_BINARY: begin
            step_val  = dir ? bin_rev : bin_fwd;
            step_wrap = dir ? (count_q == ZERO) : (count_q == ALL_ONES);
         end
         MODE_GRAY: begin
            step_val  = dir ? gray_rev : gray_fwd;
            step_wrap = dir ? (count_q == ZERO) : (count_q == MSB_ONLY);
         end
         default: begin
            step_val  = count_q;
            step_wrap = 1'b0;
         end
      endcase
   end

   always_comb begin
      count_d = count_q;
      wrap_d  = 1'b0;
      if (load) begin
         count_d = data_in;
      end else if (en) begin
         if (illegal) begin
`ifdef SEQCNT_RECOVER_EN
            count_d = (mode_sel == MODE_RING) ? ONE : ZERO;
`else
            count_d = count_q;
`endif
         end else begin
            count_d = step_val;
            wrap_d  = step_wrap;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count_q <= ONE;
         wrap_q  <= 1'b0;
      end else begin
         count_q <= count_d;
         wrap_q  <= wrap_d;
      end
   end

   assign count = count_q;
   assign wrap  = wrap_q;

endmodule

// File: tb/tb_seq_counter.sv
// Bench for seq_counter: table-driven sequence model checked every cycle, plus directed literal checks.
module tb_seq_counter;

   localparam int W = 4;

   logic         clk;
   logic         reset;
   logic         en;
   logic         load;
   logic         dir;
   logic [1:0]   mode;
   logic [W-1:0] data_in;
   logic [W-1:0] count;
   logic         wrap;
   logic         illegal;

   int n_checks = 0;
   int n_fail   = 0;
   logic check_en = 1'b0;

   logic [W-1:0] m_count;
   logic         m_wrap;

   seq_counter #(.WIDTH(W)) dut (
      .clk     (clk),
      .reset   (reset),
      .en      (en),
      .load    (load),
      .dir     (dir),
      .mode    (mode),
      .data_in (data_in),
      .count   (count),
      .wrap    (wrap),
      .illegal (illegal)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Each mode is an ordered table of states; stepping moves one index, wrapping crosses the table end.
   function automatic int seq_len(input logic [1:0] m);
      if (m == 2'd0) return W;
      if (m == 2'd1) return 2 * W;
      return 1 << W;
   endfunction

   function automatic logic [W-1:0] seq_val(input logic [1:0] m, input int idx);
      int v;
      v = 0;
      case (m)
         2'd0: v = 1 << idx;
         2'd1: v = (idx <= W) ? ((1 << idx) - 1) : (((1 << W) - 1) & (((1 << W) - 1) << (idx - W)));
         2'd2: v = idx;
         default: v = idx ^ (idx >> 1);
      endcase
      return v[W-1:0];
   endfunction

   function automatic int find_idx(input logic [1:0] m, input logic [W-1:0] val);
      for (int i = 0; i < seq_len(m); i++) begin
         if (seq_val(m, i) == val) return i;
      end
      return -1;
   endfunction

   function automatic logic [W-1:0] model_next(input logic [1:0] m, input logic d, input logic [W-1:0] cur);
      int idx;
      int len;
      logic [W-1:0] seed;
      idx  = find_idx(m, cur);
      len  = seq_len(m);
      seed = '0;
      if (m == 2'd0) seed[0] = 1'b1;
      if (idx < 0) begin
`ifdef SEQCNT_RECOVER_EN
         return seed;
`else
         return cur;
`endif
      end
      if (!d) return seq_val(m, (idx + 1) % len);
      return seq_val(m, (idx + len - 1) % len);
   endfunction

   function automatic logic model_wrap(input logic [1:0] m, input logic d, input logic [W-1:0] cur);
      int idx;
      idx = find_idx(m, cur);
      if (idx < 0) return 1'b0;
      if (!d) return (idx == seq_len(m) - 1);
      return (idx == 0);
   endfunction

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_count <= 1;
         m_wrap  <= 1'b0;
      end else if (load) begin
         m_count <= data_in;
         m_wrap  <= 1'b0;
      end else if (en) begin
         m_count <= model_next(mode, dir, m_count);
         m_wrap  <= model_wrap(mode, dir, m_count);
      end else begin
         m_wrap  <= 1'b0;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (check_en) begin
         check("model_count", 32'(count), 32'(m_count));
         check("model_wrap", 32'(wrap), 32'(m_wrap));
         check("model_illegal", 32'(illegal), 32'(find_idx(mode, m_count) < 0));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic e, input logic l, input logic d, input logic [1:0] m,
                        input logic [W-1:0] di);
      en      = e;
      load    = l;
      dir     = d;
      mode    = m;
      data_in = di;
   endtask

   task automatic expect_out(input string name, input logic [W-1:0] c, input logic w);
      check({name, "_count"}, 32'(count), 32'(c));
      check({name, "_wrap"}, 32'(wrap), 32'(w));
   endtask

   logic [W-1:0] john_exp [8];

   initial begin
      john_exp = '{4'h1, 4'h3, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8, 4'h0};
      reset = 1'b1;
      drive(1'b0, 1'b0, 1'b0, 2'd0, '0);
      tick();
      tick();
      reset = 1'b0;
      expect_out("reset", 4'h1, 1'b0);
      check("reset_illegal", 32'(illegal), 32'd0);
      check_en = 1'b1;

      // Ring forward through a full lap.
      drive(1'b1, 1'b0, 1'b0, 2'd0, '0);
      tick(); expect_out("ring1", 4'h2, 1'b0);
      tick(); expect_out("ring2", 4'h4, 1'b0);
      tick(); expect_out("ring3", 4'h8, 1'b0);
      tick(); expect_out("ring4", 4'h1, 1'b1);
      tick(); expect_out("ring5", 4'h2, 1'b0);

      // Johnson forward from zero, then reverse.
      drive(1'b0, 1'b1, 1'b0, 2'd1, 4'h0);
      tick(); expect_out("john_load", 4'h0, 1'b0);
      drive(1'b1, 1'b0, 1'b0, 2'd1, '0);
      for (int i = 0; i < 8; i++) begin
         tick();
         expect_out("john_fwd", john_exp[i], (i == 7));
      end
      drive(1'b1, 1'b0, 1'b1, 2'd1, '0);
      tick(); check("john_rev_count", 32'(count), 32'h8);

      // Binary reverse from reset, then Gray forward across its end.
      #2 reset = 1'b1;
      #1 reset = 1'b0;
      drive(1'b1, 1'b0, 1'b1, 2'd2, '0);
      tick(); expect_out("bin_rev1", 4'h0, 1'b0);
      tick(); expect_out("bin_rev2", 4'hF, 1'b1);
      tick(); expect_out("bin_rev3", 4'hE, 1'b0);
      drive(1'b0, 1'b1, 1'b0, 2'd3, 4'h8);
      tick(); expect_out("gray_load", 4'h8, 1'b0);
      drive(1'b1, 1'b0, 1'b0, 2'd3, '0);
      tick(); expect_out("gray_fwd1", 4'h0, 1'b1);
      tick(); expect_out("gray_fwd2", 4'h1, 1'b0);

      // Illegal ring state.
      drive(1'b0, 1'b1, 1'b0, 2'd0, 4'h6);
      tick(); expect_out("ill_load", 4'h6, 1'b0);
      check("ill_flag", 32'(illegal), 32'd1);
      drive(1'b1, 1'b0, 1'b0, 2'd0, '0);
`ifdef SEQCNT_RECOVER_EN
      tick(); expect_out("recover", 4'h1, 1'b0);
      check("recover_illegal", 32'(illegal), 32'd0);
      tick(); expect_out("recover2", 4'h2, 1'b0);
      tick(); expect_out("recover3", 4'h4, 1'b0);
`else
      for (int i = 0; i < 3; i++) begin
         tick(); expect_out("ill_hold", 4'h6, 1'b0);
         check("ill_hold_flag", 32'(illegal), 32'd1);
      end
`endif

      // Load beats enable, then hold.
      drive(1'b1, 1'b1, 1'b0, 2'd0, 4'h2);
      tick(); expect_out("load_pri", 4'h2, 1'b0);
      drive(1'b0, 1'b0, 1'b0, 2'd0, '0);
      tick(); expect_out("hold1", 4'h2, 1'b0);
      tick(); expect_out("hold2", 4'h2, 1'b0);

      // Asynchronous reset between edges.
      drive(1'b1, 1'b0, 1'b0, 2'd0, '0);
      tick(); expect_out("pre_rst1", 4'h4, 1'b0);
      tick(); expect_out("pre_rst2", 4'h8, 1'b0);
      #2 reset = 1'b1;
      #1 expect_out("async_rst", 4'h1, 1'b0);
      reset = 1'b0;
      tick(); expect_out("post_rst", 4'h2, 1'b0);

      // Mode and direction changes continue from the current count.
      drive(1'b1, 1'b0, 1'b0, 2'd2, '0);
      tick(); expect_out("to_bin", 4'h3, 1'b0);
      drive(1'b1, 1'b0, 1'b0, 2'd1, '0);
      tick(); expect_out("to_john", 4'h7, 1'b0);
      drive(1'b1, 1'b0, 1'b1, 2'd3, '0);
      tick(); expect_out("to_gray_rev", 4'h6, 1'b0);

      // Every mode and direction with a toggling enable, model-checked.
      for (int m = 0; m < 4; m++) begin
         for (int d = 0; d < 2; d++) begin
            drive(1'b0, 1'b1, d[0], m[1:0], 4'h1);
            tick();
            for (int k = 0; k < 6; k++) begin
               drive((k != 2), 1'b0, d[0], m[1:0], '0);
               tick();
            end
         end
      end

      drive(1'b0, 1'b0, 1'b0, 2'd0, '0);
      tick();
      @(negedge clk);
      #1;
      check_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
